// File: rtl/xs_gfx_sdr_arbiter.sv
// xs_gfx_sdr_arbiter: round-robin arbiter serialising per-layer ROM fetches onto one SDRAM read port.
// Optional watchdog enabled by defining XS_SDR_ARB_WATCHDOG_EN.
module xs_gfx_sdr_arbiter #(
  parameter int NCLI = 4,
  parameter int AW   = 25,
  parameter int DW   = 16,
  parameter int TMO  = 255
) (
  input  logic              clk_ram,
  input  logic              RESET,
  input  logic [NCLI-1:0]   cli_req,
  input  logic [NCLI*AW-1:0] cli_addr,
  output logic [NCLI-1:0]   cli_rdy,
  output logic [DW-1:0]     cli_data,
  output logic [AW-1:0]     ram_addr,
  output logic              ram_req,
  input  logic              ram_rdy,
  input  logic [DW-1:0]     ram_data,
  output logic [7:0]        ovf_cnt
);
  localparam int GW = NCLI > 1 ? $clog2(NCLI) : 1;
  typedef enum logic {IDLE, WAIT} state_t;
  state_t r_state, w_state_nxt;
  logic [NCLI-1:0] r_pend, r_cli_rdy, w_clr, w_ovf;
  logic [AW-1:0]   r_paddr [NCLI];
  logic [AW-1:0]   r_ram_addr;
  logic [DW-1:0]   r_cli_data;
  logic [GW-1:0]   r_rr, r_gnt, w_win;
  logic [7:0]      r_ovf, w_ovf_nxt;
  logic            r_ram_req, w_grant, w_done, w_tmo;
  int              w_ovf_sum;
  assign cli_rdy  = r_cli_rdy;
  assign cli_data = r_cli_data;
  assign ram_addr = r_ram_addr;
  assign ram_req  = r_ram_req;
  assign ovf_cnt  = r_ovf;
  // Round-robin winner: first pending client at or after the pointer
  always_comb begin
    w_win = r_rr;
    for (int i = NCLI - 1; i >= 0; i--)
      if (r_pend[(int'(r_rr) + i) % NCLI]) w_win = GW'((int'(r_rr) + i) % NCLI);
  end
  assign w_grant = (r_state == IDLE) && |r_pend;
  assign w_clr   = w_grant ? (NCLI'(1) << w_win) : '0;
  // A new request on the grant edge re-arms the slot, so only non-granted overwrites count
  assign w_ovf   = cli_req & r_pend & ~w_clr;
  // Saturating overflow count, allowing several clients to overwrite on one edge
  always_comb begin
    w_ovf_sum = int'(r_ovf);
    for (int i = 0; i < NCLI; i++) w_ovf_sum += int'(w_ovf[i]);
  end
  assign w_ovf_nxt = w_ovf_sum > 255 ? 8'hFF : w_ovf_sum[7:0];
`ifdef XS_SDR_ARB_WATCHDOG_EN
  logic [7:0] r_wdt;
  // Count cycles spent in WAIT; cleared whenever the FSM is idle
  always_ff @(posedge clk_ram or posedge RESET)
    if (RESET) r_wdt <= 8'd0;
    else r_wdt <= (r_state == WAIT) ? r_wdt + 8'd1 : 8'd0;
  assign w_tmo = (r_state == WAIT) && !ram_rdy && (r_wdt == 8'(TMO - 1));
`else
  assign w_tmo = 1'b0;
`endif
  assign w_done = (r_state == WAIT) && (ram_rdy || w_tmo);
  // FSM state register
  always_ff @(posedge clk_ram or posedge RESET)
    if (RESET) r_state <= IDLE;
    else r_state <= w_state_nxt;
  // FSM next state
  always_comb begin
    w_state_nxt = w_grant ? WAIT : w_done ? IDLE : r_state;
  end
  // Grant issue, completion return, pending flags and overflow count
  always_ff @(posedge clk_ram or posedge RESET)
    if (RESET) begin
      r_pend     <= '0;
      r_rr       <= '0;
      r_gnt      <= '0;
      r_ram_req  <= 1'b0;
      r_ram_addr <= '0;
      r_cli_rdy  <= '0;
      r_cli_data <= '1;
      r_ovf      <= 8'd0;
    end else begin
      r_ram_req <= w_grant;
      r_cli_rdy <= w_done ? (NCLI'(1) << r_gnt) : '0;
      if (w_grant) begin
        r_ram_addr <= r_paddr[w_win];
        r_gnt      <= w_win;
        r_rr       <= GW'((int'(w_win) + 1) % NCLI);
      end
      if (w_done) r_cli_data <= ram_rdy ? ram_data : '1;
      r_pend <= (r_pend & ~w_clr) | cli_req;
      r_ovf  <= w_ovf_nxt;
    end
  // Pending address slots; validity is tracked by r_pend, so no reset needed
  always_ff @(posedge clk_ram)
    for (int i = 0; i < NCLI; i++)
      if (cli_req[i]) r_paddr[i] <= cli_addr[i*AW +: AW];
endmodule
